ysyx_22040931_store_unit: RTL

Store-execution unit for the RV64 core: consumes the store width code (`memwop`) produced by the S-type decoder, together with the effective address and rs2 data. It formats the data into a 64-bit lane-replicated beat with byte strobes and drives one AXI4-Lite-style write transaction (AW/W/B) to the data memory. It reports completion or error back to the pipeline, which stalls while the unit is busy.

---
 rtl/ysyx_22040931_store_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040931_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040931_store_unit
// Purpose  : RV64 store execution unit. Formats rs2 data into a lane-replicated
//            64-bit beat with byte strobes and issues one AW/W/B write.
// Options  : YSYX_22040931_STORE_MISALIGN_EN enables misalignment trapping.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040931_store_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [2:0]        req_wop,
    output logic              done,
    output logic              err,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [7:0]        wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_RESP = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [2:0] c_W_NONE = 3'b000;
    localparam logic [2:0] c_W_ONE  = 3'b001;
    localparam logic [2:0] c_W_DOU  = 3'b010;
    localparam logic [2:0] c_W_FOR  = 3'b011;
    localparam logic [2:0] c_W_EIG  = 3'b100;

    localparam logic [7:0] c_STRB_B = 8'h01;
    localparam logic [7:0] c_STRB_H = 8'h03;
    localparam logic [7:0] c_STRB_W = 8'h0F;
    localparam logic [7:0] c_STRB_D = 8'hFF;

    state_t              state_q,   state_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q,  wvalid_d;
    logic                err_q,     err_d;
    logic [ADDR_W-1:0]   awaddr_q,  awaddr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [7:0]          wstrb_q,   wstrb_d;

    logic [2:0]          w_off;
    logic [DATA_W-1:0]   w_fmt_data;
    logic [7:0]          w_fmt_strb;
    logic                w_illegal;
    logic                w_misalign;

    assign w_off     = req_addr[2:0];
    assign w_illegal = (req_wop > c_W_EIG);

    // Replicate the significant low bytes across every lane so the slave can
    // pick the bytes selected by wstrb without any shifting of its own.
    always_comb begin
        w_fmt_data = '0;
        w_fmt_strb = '0;
        case (req_wop)
            c_W_ONE: begin
                w_fmt_data = {8{req_data[7:0]}};
                w_fmt_strb = c_STRB_B << w_off;
            end
            c_W_DOU: begin
                w_fmt_data = {4{req_data[15:0]}};
                w_fmt_strb = c_STRB_H << w_off;
            end
            c_W_FOR: begin
                w_fmt_data = {2{req_data[31:0]}};
                w_fmt_strb = c_STRB_W << w_off;
            end
            c_W_EIG: begin
                w_fmt_data = req_data;
                w_fmt_strb = c_STRB_D;
            end
            default: begin
                w_fmt_data = '0;
                w_fmt_strb = '0;
            end
        endcase
    end

`ifdef YSYX_22040931_STORE_MISALIGN_EN
    always_comb begin
        w_misalign = 1'b0;
        case (req_wop)
            c_W_DOU: w_misalign = w_off[0];
            c_W_FOR: w_misalign = |w_off[1:0];
            c_W_EIG: w_misalign = |w_off;
            default: w_misalign = 1'b0;
        endcase
    end
`else
    // Strobes shifted past the doubleword are simply truncated.
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        err_d     = err_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    err_d = 1'b0;
                    if (req_wop == c_W_NONE) begin
                        state_d = S_FIN;
                    end else if (w_illegal || w_misalign) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d   = S_SEND;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = {req_addr[ADDR_W-1:3], 3'b000};
                        wdata_d   = w_fmt_data;
                        wstrb_d   = w_fmt_strb;
                    end
                end
            end
            S_SEND: begin
                // Each channel retires on its own handshake, in any order.
                awvalid_d = awvalid_q & ~awready;
                wvalid_d  = wvalid_q & ~wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bvalid) begin
                    err_d   = (bresp != 2'b00);
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            err_q     <= err_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_FIN);
    assign bready    = (state_q == S_RESP);
    assign err       = err_q;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign awaddr    = awaddr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;

endmodule
`default_nettype wire
